// File: rtl/csp_split_pkg.sv
// Shared constants and helpers for the N-way CSP split.
package csp_split_pkg;

  localparam int ERR_W = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/csp_split_slot.sv
// One-entry output buffer: a full flag plus a data register.
module csp_split_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             drain_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  // A load always wins over a drain; callers only load when the slot can accept.
  always_comb begin
    full_d = load_i | (full_q & ~drain_i);
    data_d = load_i ? data_i : data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/csp_split_n.sv
// N-way CSP split: routes a data token to the selected output slot, or to all in broadcast.
module csp_split_n
  import csp_split_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NOUT  = 4,
  parameter bit BCAST = 1'b0,
  localparam int SEL_W = clog2(NOUT + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  sel_valid,
  output logic                  sel_ready,
  output logic [NOUT*WIDTH-1:0] out_data,
  output logic [NOUT-1:0]       out_valid,
  input  logic [NOUT-1:0]       out_ready,
  output logic [ERR_W-1:0]      err_cnt
);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [NOUT-1:0]  full;
  logic [NOUT-1:0]  can_accept;
  logic [NOUT-1:0]  sel_hit;
  logic [NOUT-1:0]  load;
  logic             legal, bcast_hit, route_ok, fire, drop;
  logic [ERR_W-1:0] err_q, err_d;

  // Decode via one-hot compare so out_ready of unaddressed outputs never gates fire.
  always_comb begin
    sel_hit = '0;
    for (int i = 0; i < NOUT; i++) begin
      sel_hit[i] = (sel == SEL_W'(i));
    end
    legal      = |sel_hit;
    bcast_hit  = BCAST && (sel == SEL_W'(NOUT));
    can_accept = ~full | out_ready;
    if (legal)          route_ok = |(sel_hit & can_accept);
    else if (bcast_hit) route_ok = &can_accept;
    else                route_ok = 1'b1;
    fire = in_valid & sel_valid & route_ok & ~reset;
    load = {NOUT{fire}} & (bcast_hit ? {NOUT{1'b1}} : sel_hit);
    drop = fire & ~legal & ~bcast_hit;
    err_d = drop ? sat_inc(err_q) : err_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= '0;
    else       err_q <= err_d;
  end

  for (genvar g = 0; g < NOUT; g++) begin : g_slot
    csp_split_slot #(.WIDTH(WIDTH)) u_slot (
      .clk     (clk),
      .reset   (reset),
      .load_i  (load[g]),
      .drain_i (out_ready[g]),
      .data_i  (in_data),
      .full_o  (full[g]),
      .data_o  (out_data[g*WIDTH +: WIDTH])
    );
  end

  assign in_ready  = fire;
  assign sel_ready = fire;
  assign out_valid = full;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_csp_split_n.sv
// Bench for csp_split_n: one BCAST=0 and one BCAST=1 instance against a queue-based model.
module tb_csp_split_n;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid, sel_valid;
  logic [2:0]  sel;
  logic [3:0]  out_ready;

  logic        in_ready0, sel_ready0, in_ready1, sel_ready1;
  logic [31:0] out_data0, out_data1;
  logic [3:0]  out_valid0, out_valid1;
  logic [7:0]  err0, err1;

  int checks = 0;
  int failures = 0;

  csp_split_n #(.WIDTH(8), .NOUT(4), .BCAST(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .sel(sel), .sel_valid(sel_valid), .sel_ready(sel_ready0), .out_data(out_data0),
    .out_valid(out_valid0), .out_ready(out_ready), .err_cnt(err0));

  csp_split_n #(.WIDTH(8), .NOUT(4), .BCAST(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .sel(sel), .sel_valid(sel_valid), .sel_ready(sel_ready1), .out_data(out_data1),
    .out_valid(out_valid1), .out_ready(out_ready), .err_cnt(err1));

  always #5 clk = ~clk;

  // Reference model: each output is a FIFO of depth one.
  logic [7:0] mq [2][4][$];
  logic [7:0] lastv [2][4];
  int         merr [2];
  bit         mfire [2];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      merr[d] = 0;
      for (int i = 0; i < 4; i++) begin
        mq[d][i].delete();
        lastv[d][i] = 8'h00;
      end
    end
  endtask

  function automatic bit model_fire(input int d);
    bit all_ok;
    if (!in_valid || !sel_valid) return 1'b0;
    if (sel < 4) return (mq[d][sel].size() == 0) || out_ready[sel];
    if (d == 1 && sel == 4) begin
      all_ok = 1'b1;
      for (int i = 0; i < 4; i++)
        if (mq[d][i].size() != 0 && !out_ready[i]) all_ok = 1'b0;
      return all_ok;
    end
    return 1'b1;
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++)
        if (mq[d][i].size() != 0 && out_ready[i]) void'(mq[d][i].pop_front());
      if (mfire[d]) begin
        if (sel < 4) begin
          mq[d][sel].push_back(in_data);
          lastv[d][sel] = in_data;
        end else if (d == 1 && sel == 4) begin
          for (int i = 0; i < 4; i++) begin
            mq[d][i].push_back(in_data);
            lastv[d][i] = in_data;
          end
        end else if (merr[d] < 255) begin
          merr[d]++;
        end
      end
    end
  endtask

  task automatic check_outs();
    logic [3:0]  eov;
    logic [31:0] eod;
    for (int d = 0; d < 2; d++) begin
      eov = '0;
      eod = '0;
      for (int i = 0; i < 4; i++) begin
        eov[i] = (mq[d][i].size() != 0);
        eod[i*8 +: 8] = eov[i] ? mq[d][i][0] : lastv[d][i];
      end
      check($sformatf("model_out_valid%0d", d), {28'h0, (d == 0) ? out_valid0 : out_valid1}, {28'h0, eov});
      check($sformatf("model_out_data%0d", d), (d == 0) ? out_data0 : out_data1, eod);
      check($sformatf("model_err%0d", d), {24'h0, (d == 0) ? err0 : err1}, merr[d]);
    end
  endtask

  task automatic step_pre();
    #1;
    for (int d = 0; d < 2; d++) mfire[d] = model_fire(d);
    check("model_in_ready0", {31'h0, in_ready0}, {31'h0, mfire[0]});
    check("model_sel_ready0", {31'h0, sel_ready0}, {31'h0, mfire[0]});
    check("model_in_ready1", {31'h0, in_ready1}, {31'h0, mfire[1]});
    check("model_sel_ready1", {31'h0, sel_ready1}, {31'h0, mfire[1]});
  endtask

  task automatic step_post();
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
  endtask

  task automatic step();
    step_pre();
    step_post();
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [2:0] s, input logic [7:0] d, input logic [3:0] r);
    in_valid  = v;
    sel_valid = v;
    sel       = s;
    in_data   = d;
    out_ready = r;
  endtask

  typedef struct {
    logic        v;
    logic [2:0]  s;
    logic [7:0]  d;
    logic [3:0]  rdy;
    logic        exp_ir;
    logic [3:0]  exp_ov;
    logic [31:0] exp_od;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{1'b1, 3'd2, 8'hA5, 4'b1111, 1'b1, 4'b0100, 32'h00A50000, 8'd0};
    tbl[1] = '{1'b0, 3'd2, 8'hA5, 4'b1111, 1'b0, 4'b0000, 32'h00A50000, 8'd0};
    tbl[2] = '{1'b1, 3'd4, 8'h11, 4'b1111, 1'b1, 4'b0000, 32'h00A50000, 8'd1};
    tbl[3] = '{1'b1, 3'd7, 8'h22, 4'b1111, 1'b1, 4'b0000, 32'h00A50000, 8'd2};
    tbl[4] = '{1'b1, 3'd1, 8'h33, 4'b1101, 1'b1, 4'b0010, 32'h00A53300, 8'd2};
    tbl[5] = '{1'b1, 3'd1, 8'h44, 4'b1101, 1'b0, 4'b0010, 32'h00A53300, 8'd2};
    tbl[6] = '{1'b1, 3'd1, 8'h44, 4'b0101, 1'b0, 4'b0010, 32'h00A53300, 8'd2};
    tbl[7] = '{1'b1, 3'd1, 8'h44, 4'b1111, 1'b1, 4'b0010, 32'h00A54400, 8'd2};
    tbl[8] = '{1'b1, 3'd3, 8'h66, 4'b1101, 1'b1, 4'b1010, 32'h66A54400, 8'd2};
    tbl[9] = '{1'b0, 3'd3, 8'h66, 4'b1111, 1'b0, 4'b0000, 32'h66A54400, 8'd2};

    reset = 1'b1;
    drive(1'b1, 3'd2, 8'hA5, 4'b1111);
    model_reset();
    #3;
    check("rst_out_valid0", {28'h0, out_valid0}, 32'h0);
    check("rst_out_valid1", {28'h0, out_valid1}, 32'h0);
    check("rst_out_data0", out_data0, 32'h0);
    check("rst_err0", {24'h0, err0}, 32'h0);
    check("rst_in_ready0", {31'h0, in_ready0}, 32'h0);
    check("rst_in_ready1", {31'h0, in_ready1}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table for the BCAST=0 instance, model keeps tracking both.
    for (int k = 0; k < 10; k++) begin
      drive(tbl[k].v, tbl[k].s, tbl[k].d, tbl[k].rdy);
      step_pre();
      check($sformatf("tbl%0d_in_ready", k), {31'h0, in_ready0}, {31'h0, tbl[k].exp_ir});
      step_post();
      check($sformatf("tbl%0d_out_valid", k), {28'h0, out_valid0}, {28'h0, tbl[k].exp_ov});
      check($sformatf("tbl%0d_out_data", k), out_data0, tbl[k].exp_od);
      check($sformatf("tbl%0d_err", k), {24'h0, err0}, {24'h0, tbl[k].exp_err});
      @(negedge clk);
    end

    // Streaming to output 0: one token per cycle in order.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 3'd0, 8'(i), 4'b1111);
      step_pre();
      check("stream_in_ready", {31'h0, in_ready0}, 32'h1);
      step_post();
      check("stream_data", {24'h0, out_data0[7:0]}, i);
      check("stream_valid", {31'h0, out_valid0[0]}, 32'h1);
      @(negedge clk);
    end

    // Broadcast on the BCAST=1 instance, then a stall on a blocked slot.
    drive(1'b0, 3'd0, 8'h00, 4'b1111);
    step();
    drive(1'b1, 3'd4, 8'h3C, 4'b1111);
    step();
    check("bcast_valid", {28'h0, out_valid1}, 32'hF);
    check("bcast_data", out_data1, 32'h3C3C3C3C);
    check("bcast_drop_valid0", {28'h0, out_valid0}, 32'h0);
    drive(1'b1, 3'd4, 8'h5A, 4'b1011);
    step_pre();
    check("bcast_stall", {31'h0, in_ready1}, 32'h0);
    step_post();
    @(negedge clk);
    drive(1'b1, 3'd4, 8'h5A, 4'b1111);
    step();
    check("bcast_resume", out_data1, 32'h5A5A5A5A);

    // Illegal selects saturate the drop counter.
    drive(1'b0, 3'd0, 8'h00, 4'b1111);
    step();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 3'd5, 8'($urandom), 4'b1111);
      step();
    end
    check("err_sat0", {24'h0, err0}, 32'd255);
    check("err_sat1", {24'h0, err1}, 32'd255);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom), 3'($urandom_range(0, 7)), 8'($urandom), 4'($urandom));
      sel_valid = 1'($urandom_range(0, 3) != 0) & in_valid | 1'($urandom_range(0, 7) == 0);
      step();
    end

    // Asynchronous reset with full slots and a token on offer.
    drive(1'b1, 3'd0, 8'hE1, 4'b0000);
    step();
    drive(1'b1, 3'd1, 8'hE2, 4'b0000);
    step();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("arst_valid0", {28'h0, out_valid0}, 32'h0);
    check("arst_valid1", {28'h0, out_valid1}, 32'h0);
    check("arst_data1", out_data1, 32'h0);
    check("arst_err0", {24'h0, err0}, 32'h0);
    check("arst_err1", {24'h0, err1}, 32'h0);
    check("arst_in_ready0", {31'h0, in_ready0}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 3'd3, 8'h9A, 4'b0000);
    step();
    check("post_rst_valid", {28'h0, out_valid0}, 32'h8);
    check("post_rst_data", {24'h0, out_data0[31:24]}, 32'h9A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
